// File: rtl/scs8hd_dlrtn_bank_pkg.sv
// Shared types and sizing helpers for the clocked latch bank and its channels.
package scs8hd_dlrtn_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_BLOCK = 2'd2
  } chan_state_e;

  // The counter must be able to hold MIN_GATE_CYC itself, since it saturates there.
  function automatic int cnt_width(input int min_gate_cyc);
    return (min_gate_cyc < 1) ? 1 : $clog2(min_gate_cyc + 1);
  endfunction

endpackage

// File: rtl/scs8hd_dlrtn_chan.sv
// One latch channel: gate-window FSM, saturating width counter, pending/stored
// registers and the transparent/committed output select.
module scs8hd_dlrtn_chan
  import scs8hd_dlrtn_bank_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_GATE_CYC = 2,
  parameter int TRANSPARENT  = 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [WIDTH-1:0] d,
  input  logic             gaten,
  input  logic             clrb,
  input  logic             viol_clr,
  output logic [WIDTH-1:0] q,
  output logic             viol
);

  localparam int             CNT_W   = cnt_width(MIN_GATE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_GATE_CYC);

  chan_state_e      state_reg, state_next;
  logic [WIDTH-1:0] stored_reg, stored_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             viol_reg, viol_next;
  logic             viol_set;
  logic [CNT_W-1:0] cnt_sat;

  assign cnt_sat = (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_reg   <= ST_IDLE;
      stored_reg  <= '0;
      pending_reg <= '0;
      cnt_reg     <= '0;
      viol_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stored_reg  <= stored_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      viol_reg    <= viol_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stored_next  = stored_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    viol_set     = 1'b0;
    if (!clrb) begin
      // A clear while the gate is open parks the channel until the gate closes once.
      stored_next  = '0;
      pending_next = '0;
      cnt_next     = '0;
      state_next   = gaten ? ST_IDLE : ST_BLOCK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!gaten) begin
            pending_next = d;
            cnt_next     = CNT_W'(1);
            state_next   = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (!gaten) begin
            pending_next = d;
            cnt_next     = cnt_sat;
          end else begin
            if (cnt_reg >= CNT_MAX) stored_next = pending_reg;
            else                    viol_set    = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end
        end
        ST_BLOCK: begin
          if (gaten) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
    viol_next = viol_set ? 1'b1 : (viol_clr ? 1'b0 : viol_reg);
  end

  always_comb begin
    q = stored_reg;
    if (!resetb || !clrb)
      q = '0;
    else if (TRANSPARENT != 0 &&
             (state_reg == ST_OPEN || (state_reg == ST_IDLE && !gaten)))
      q = d;
  end

  assign viol = viol_reg;

endmodule

// File: rtl/scs8hd_dlrtn_bank.sv
// Bank of NCH independent clocked gate-latch channels; slices the buses and
// fans out the shared reset and violation clear.
module scs8hd_dlrtn_bank
  import scs8hd_dlrtn_bank_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NCH          = 4,
  parameter int MIN_GATE_CYC = 2,
  parameter int TRANSPARENT  = 1
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic [NCH*WIDTH-1:0] D,
  input  logic [NCH-1:0]       GATEN,
  input  logic [NCH-1:0]       CLRB,
  input  logic                 VIOL_CLR,
  output logic [NCH*WIDTH-1:0] Q,
  output logic [NCH-1:0]       VIOL
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    scs8hd_dlrtn_chan #(
      .WIDTH       (WIDTH),
      .MIN_GATE_CYC(MIN_GATE_CYC),
      .TRANSPARENT (TRANSPARENT)
    ) u_chan (
      .clk     (CLK),
      .resetb  (RESETB),
      .d       (D[gi*WIDTH +: WIDTH]),
      .gaten   (GATEN[gi]),
      .clrb    (CLRB[gi]),
      .viol_clr(VIOL_CLR),
      .q       (Q[gi*WIDTH +: WIDTH]),
      .viol    (VIOL[gi])
    );
  end

endmodule

// File: tb/tb_scs8hd_dlrtn_bank.sv
// Randomised and directed bench for the latch bank; two instances (transparent
// MIN=2 and registered-only MIN=3) are checked against a window-length model.
module tb_scs8hd_dlrtn_bank;

  localparam int W  = 8;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            resetb;
  logic [NC*W-1:0] d;
  logic [NC-1:0]   gaten;
  logic [NC-1:0]   clrb;
  logic            viol_clr;
  logic [NC*W-1:0] q_a, q_b;
  logic [NC-1:0]   viol_a, viol_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state per instance (0 = default, 1 = registered MIN=3) and channel.
  int        m_minc[2]   = '{2, 3};
  bit        m_transp[2] = '{1'b1, 1'b0};
  logic [7:0] m_stored[2][NC];
  logic [7:0] m_last[2][NC];
  int        m_len[2][NC];
  bit        m_blk[2][NC];
  bit        m_viol[2][NC];

  always #5 clk = ~clk;

  scs8hd_dlrtn_bank dut_a (
    .CLK(clk), .RESETB(resetb), .D(d), .GATEN(gaten), .CLRB(clrb),
    .VIOL_CLR(viol_clr), .Q(q_a), .VIOL(viol_a)
  );

  scs8hd_dlrtn_bank #(.WIDTH(8), .NCH(4), .MIN_GATE_CYC(3), .TRANSPARENT(0)) dut_b (
    .CLK(clk), .RESETB(resetb), .D(d), .GATEN(gaten), .CLRB(clrb),
    .VIOL_CLR(viol_clr), .Q(q_b), .VIOL(viol_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_q(input int k, input int c);
    if (!resetb || !clrb[c]) return 8'h00;
    if (m_transp[k] && !m_blk[k][c] && (m_len[k][c] > 0 || !gaten[c])) return d[c*W +: W];
    return m_stored[k][c];
  endfunction

  task automatic compare_all();
    logic [31:0] eq_a, eq_b;
    logic [3:0]  ev_a, ev_b;
    for (int c = 0; c < NC; c++) begin
      eq_a[c*W +: W] = exp_q(0, c);
      eq_b[c*W +: W] = exp_q(1, c);
      ev_a[c] = m_viol[0][c];
      ev_b[c] = m_viol[1][c];
    end
    check_eq("q_a", q_a, eq_a);
    check_eq("viol_a", {28'd0, viol_a}, {28'd0, ev_a});
    check_eq("q_b", q_b, eq_b);
    check_eq("viol_b", {28'd0, viol_b}, {28'd0, ev_b});
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) begin
        bit set_v;
        set_v = 1'b0;
        if (!resetb) begin
          m_stored[k][c] = 8'h00; m_last[k][c] = 8'h00;
          m_len[k][c] = 0; m_blk[k][c] = 1'b0; m_viol[k][c] = 1'b0;
          continue;
        end
        if (!clrb[c]) begin
          m_stored[k][c] = 8'h00;
          m_len[k][c]    = 0;
          m_blk[k][c]    = !gaten[c];
        end else if (m_blk[k][c]) begin
          if (gaten[c]) m_blk[k][c] = 1'b0;
        end else if (!gaten[c]) begin
          m_len[k][c]++;
          m_last[k][c] = d[c*W +: W];
        end else if (m_len[k][c] > 0) begin
          if (m_len[k][c] >= m_minc[k]) m_stored[k][c] = m_last[k][c];
          else                          set_v = 1'b1;
          m_len[k][c] = 0;
        end
        if (set_v)         m_viol[k][c] = 1'b1;
        else if (viol_clr) m_viol[k][c] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    $display("cyc=%0d rstb=%b gaten=%b clrb=%b vclr=%b d=%h q_a=%h viol_a=%b q_b=%h viol_b=%b",
             cyc, resetb, gaten, clrb, viol_clr, d, q_a, viol_a, q_b, viol_b);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic drive(input int c, input bit open, input logic [7:0] v);
    gaten[c]      = !open;
    d[c*W +: W]   = v;
  endtask

  task automatic do_reset();
    resetb = 1'b0; d = 32'hFFFF_FFFF; gaten = 4'h0; clrb = 4'hF; viol_clr = 1'b0;
    cycle();
    resetb = 1'b1; gaten = 4'hF; d = 32'h0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_q_a", q_a, 32'h0);
    check_eq("rst_viol_a", {28'd0, viol_a}, 32'h0);

    // Normal capture on channel 0.
    drive(0, 1, 8'h11); cycle();
    drive(0, 1, 8'h22); cycle();
    drive(0, 1, 8'h5A); cycle();
    check_eq("cap_transp", {24'd0, q_a[7:0]}, 32'h5A);
    drive(0, 0, 8'h00); cycle();
    check_eq("cap_q0", {24'd0, q_a[7:0]}, 32'h5A);
    check_eq("cap_viol0", {31'd0, viol_a[0]}, 32'h0);

    // Short window on channel 1 after storing 0x33.
    drive(1, 1, 8'h33); cycle(); cycle();
    drive(1, 0, 8'h00); cycle();
    drive(1, 1, 8'hC3); cycle();
    check_eq("short_open", {24'd0, q_a[15:8]}, 32'hC3);
    drive(1, 0, 8'h00); cycle();
    check_eq("short_revert", {24'd0, q_a[15:8]}, 32'h33);
    check_eq("short_viol", {31'd0, viol_a[1]}, 32'h1);
    cycle();
    check_eq("short_hold", {31'd0, viol_a[1]}, 32'h1);
    viol_clr = 1'b1; cycle(); viol_clr = 1'b0;
    check_eq("viol_clr", {31'd0, viol_a[1]}, 32'h0);

    // Clear mid-window on channel 2, then a clean window.
    drive(2, 1, 8'h77); cycle(); cycle();
    clrb[2] = 1'b0; cycle(); clrb[2] = 1'b1;
    cycle(); cycle();
    drive(2, 0, 8'h00); cycle();
    check_eq("clr_q2", {24'd0, q_a[23:16]}, 32'h0);
    check_eq("clr_viol2", {31'd0, viol_a[2]}, 32'h0);
    drive(2, 1, 8'h9E); cycle(); cycle();
    drive(2, 0, 8'h00); cycle();
    check_eq("clr_recommit", {24'd0, q_a[23:16]}, 32'h9E);

    // Same-edge: ch3 short close with VIOL_CLR, ch0 commit.
    drive(0, 1, 8'hA5); cycle();
    drive(3, 1, 8'h3C); cycle();
    drive(0, 0, 8'h00); drive(3, 0, 8'h00); viol_clr = 1'b1; cycle(); viol_clr = 1'b0;
    check_eq("sim_viol3", {31'd0, viol_a[3]}, 32'h1);
    check_eq("sim_q0", {24'd0, q_a[7:0]}, 32'hA5);
    check_eq("sim_q2", {24'd0, q_a[23:16]}, 32'h9E);

    // Registered-only MIN=3 instance from a clean reset.
    do_reset();
    drive(0, 1, 8'h42); cycle(); cycle();
    check_eq("b_hidden", {24'd0, q_b[7:0]}, 32'h0);
    cycle();
    drive(0, 0, 8'h00); cycle();
    check_eq("b_commit", {24'd0, q_b[7:0]}, 32'h42);
    check_eq("b_noviol", {31'd0, viol_b[0]}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h10 + 8'(i)); cycle();
    end
    drive(0, 0, 8'h00); cycle();
    check_eq("b_sat", {24'd0, q_b[7:0]}, 32'h14);
    check_eq("b_sat_viol", {31'd0, viol_b[0]}, 32'h0);

    // Random traffic checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 2) == 0) gaten[c] = ~gaten[c];
      d = $urandom();
      for (int c = 0; c < NC; c++) clrb[c] = ($urandom_range(0, 19) != 0);
      viol_clr = ($urandom_range(0, 9) == 0);
      resetb   = ($urandom_range(0, 99) != 0);
      cycle();
    end
    resetb = 1'b1; clrb = 4'hF; viol_clr = 1'b0; gaten = 4'hF;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scs8hd_dlrtn_bank.md
Name: scs8hd_dlrtn_bank

Overview:
- Parametrised, clocked successor to the single-bit active-low-gate, active-low-reset latch.
- Holds NCH channels of WIDTH bits. Each channel has:
  - an active-low gate, GATEN[i];
  - an active-low per-channel clear, CLRB[i];
  - a minimum gate-open-width check with sticky violation flag.
- A gate window shorter than MIN_GATE_CYC is rolled back instead of corrupting the stored value.
- Sits in the synchronous register-file and config-latch replacement flow for gate-level-friendly digital blocks.

Parameters:
- WIDTH, 8: data bits per channel (>=1).
- NCH, 4: number of independent channels (>=1).
- MIN_GATE_CYC, 2: minimum consecutive gate-open cycles for a valid capture (>=1; 1 disables violations).
- TRANSPARENT, 1: 1 = Q follows D combinationally while the gate is open; 0 = Q shows only the committed value.

Ports:
- CLK  input  1  sole clock; all state updates on the rising edge.
- RESETB  input  1  synchronous, active-low reset.
- D  input  NCH*WIDTH  channel data; channel i is bits [i*WIDTH +: WIDTH].
- GATEN  input  NCH  active-low gate per channel.
- CLRB  input  NCH  synchronous, active-low per-channel clear.
- VIOL_CLR  input  1  synchronous clear of all VIOL bits.
- Q  output  NCH*WIDTH  channel outputs.
- VIOL  output  NCH  sticky per-channel min-width violation flag.

Behaviour:
- Per-channel state:
  - stored[WIDTH]: committed value.
  - pending[WIDTH]: capture in progress.
  - cnt: saturating at MIN_GATE_CYC, width $clog2(MIN_GATE_CYC+1).
  - FSM {IDLE, OPEN, BLOCK}.
- Priority at each edge: RESETB low > CLRB[i] low > gate logic. VIOL_CLR is lower priority than a same-edge VIOL set.
- RESETB==0 at edge: for all channels, stored=0, pending=0, cnt=0, state=IDLE, VIOL=0.
- CLRB[i]==0 at edge: stored=0, pending=0, cnt=0. Any window is aborted without commit or VIOL. State becomes BLOCK if GATEN[i]==0, else IDLE.
- IDLE:
  - GATEN[i]==0: pending<=D_i, cnt<=1, go to OPEN.
  - Otherwise stay in IDLE.
- OPEN:
  - GATEN[i]==0: pending<=D_i, cnt<=min(cnt+1, MIN_GATE_CYC).
  - GATEN[i]==1 and cnt>=MIN_GATE_CYC: stored<=pending, cnt<=0, go to IDLE.
  - GATEN[i]==1 and cnt<MIN_GATE_CYC: stored unchanged, VIOL[i]<=1, cnt<=0, go to IDLE.
- BLOCK (recovery after a clear during an open gate):
  - GATEN[i]==1: go to IDLE. No capture until the gate closes once.
- Q_i, combinational:
  - 0 while RESETB==0 or CLRB[i]==0.
  - Otherwise D_i when TRANSPARENT==1, state==OPEN or (state==IDLE and GATEN[i]==0).
  - Otherwise stored.
- Timing:
  - Committed value appears on Q one cycle after the closing edge (latency 1).
  - Transparent path has latency 0.
  - After a rejected short window, Q reverts to the old stored value.
- VIOL[i] is set at the closing edge of a short window. It stays set until RESETB or VIOL_CLR (clear-only edge).
- Channels are fully independent. Simultaneous events on different channels do not interact.
- cnt saturates and never wraps, regardless of window length.
- Post-reset outputs: Q=0 when gates are closed, VIOL=0.

Decomposition:
- Package scs8hd_dlrtn_bank_pkg holds:
  - the channel state enum {IDLE, OPEN, BLOCK};
  - a cnt-width localparam function of MIN_GATE_CYC.
- One sub-module, scs8hd_dlrtn_chan (one channel: FSM, cnt, pending, stored, Q mux), instantiated NCH times by generate.
- The top level only slices buses and fans out RESETB/VIOL_CLR.

Test Plan:
- Reset: RESETB=0 for 1 edge with D=0xFFFFFFFF, GATEN=0x0 → after the edge, Q reads 0 while RESETB low, VIOL=0x0, all FSMs in IDLE.
- Normal capture, ch0:
  - Stimulus: GATEN[0]=0 for 3 edges with D0=0x11, 0x22, 0x5A, then GATEN[0]=1.
  - Response: Q0 follows D while open; Q0=0x5A from the cycle after close; VIOL[0]=0.
- Short window, ch1:
  - Stimulus: stored 0x33, GATEN[1]=0 for 1 edge with D1=0xC3.
  - Response: Q1=0xC3 while open, back to 0x33 after close; VIOL[1]=1 and holds.
  - A later VIOL_CLR pulse clears it.
- Clear mid-window, ch2:
  - Stimulus: open 2 edges with D2=0x77; CLRB[2]=0 for 1 edge; gate held open 2 more edges, then closed.
  - Response: Q2=0 throughout and after; no commit; VIOL[2]=0.
  - A following 2-cycle window with D2=0x9E commits 0x9E.
- Simultaneous events:
  - Stimulus: VIOL_CLR=1 on the same edge as a short-window close on ch3; ch0 commits 0xA5 on the same edge.
  - Response: VIOL[3]=1, Q0=0xA5, other channels unchanged.
- TRANSPARENT=0, MIN_GATE_CYC=3 instance:
  - 3-edge window with D0=0x42 → Q0 unchanged during the window, 0x42 one cycle after close.
  - A 5-edge window → cnt saturates at 3 and the commit is correct.
